// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one combinational fp_mul between NREQ requesters.
// Round-robin arbitration, one multiply in flight, operands held on mul_a/mul_b
// for LAT cycles, product returned to the winner with a one-cycle strobe.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   req_valid    per-requester request valid              [NREQ]
//   req_a/req_b  packed operands, requester i at [32i+:32] [32*NREQ]
//   req_ready    one-hot grant (combinational, IDLE only)  [NREQ]
//   rsp_valid    one-hot response strobe                   [NREQ]
//   rsp_result   product for the flagged requester         [32]
//   mul_a/mul_b  operands to the shared fp_mul             [32]
//   mul_result   product from the shared fp_mul            [32]
//   busy         high whenever the arbiter is not idle
module fp_mul_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned LAT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_result,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_result,
  output logic                 busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 2;
  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [GW-1:0]   r_g;
  logic [GW-1:0]   r_last;
  logic [DW-1:0]   r_op_a;
  logic [DW-1:0]   r_op_b;
  logic [DW-1:0]   r_res;
  logic [NREQ-1:0] r_rsp_valid;
  logic            r_busy;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [GW-1:0]   w_hi;
  logic            w_hi_vld;
  logic [GW-1:0]   w_lo;
  logic            w_lo_vld;
  logic [GW-1:0]   w_win;
  logic            w_win_vld;
  logic [DW-1:0]   w_sel_a;
  logic [DW-1:0]   w_sel_b;
  logic [NREQ-1:0] w_ready;
  logic            w_hs;
  logic            w_cap;

  // Round-robin: first valid above last_grant, else first valid at/below it.
  always_comb begin
    w_hi     = '0;
    w_hi_vld = 1'b0;
    w_lo     = '0;
    w_lo_vld = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_hi_vld && req_valid[i] && (GW'(i) > r_last)) begin
        w_hi     = GW'(i);
        w_hi_vld = 1'b1;
      end
      if (!w_lo_vld && req_valid[i] && (GW'(i) <= r_last)) begin
        w_lo     = GW'(i);
        w_lo_vld = 1'b1;
      end
    end
    w_win     = w_hi_vld ? w_hi : w_lo;
    w_win_vld = w_hi_vld | w_lo_vld;
  end

  // Operand slice of the current winner.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (GW'(i) == w_win) begin
        w_sel_a = req_a[i*DW +: DW];
        w_sel_b = req_b[i*DW +: DW];
      end
    end
  end

  // Next-state and combinational grant.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = '0;
    w_hs        = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld && !reset) begin
          w_ready     = NREQ'(1) << w_win;
          w_hs        = 1'b1;
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CW'(LAT - 1);
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_cap       = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_g         <= '0;
      r_last      <= GW'(NREQ - 1);
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_res       <= '0;
      r_rsp_valid <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_hs) begin
        r_op_a <= w_sel_a;
        r_op_b <= w_sel_b;
        r_g    <= w_win;
      end
      if (w_cap) begin
        r_res <= mul_result;
      end
      if (r_state == S_RESP) begin
        r_last <= r_g;
      end
      // Strobe is registered so it lines up exactly with the RESP cycle.
      r_rsp_valid <= (w_state_nxt == S_RESP) ? (NREQ'(1) << r_g) : '0;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign req_ready  = w_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_res;
  assign mul_a      = r_op_a;
  assign mul_b      = r_op_b;
  assign busy       = r_busy;

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one combinational fp_mul instance between NREQ requesters, e.g. the FP execute path and a future vector/accumulate helper.
- Arbitrates round-robin and launches one multiply at a time.
- Holds the multiplier operands stable for LAT cycles so the multiplier can later be retimed or multicycle-constrained.
- Captures the product and returns it to the winning requester with a one-cycle response pulse.

Parameters:
- NREQ, 2, number of requesters (1..8).
- LAT, 1, cycles the operands are held on mul_a/mul_b before mul_result is captured (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  32*NREQ  packed operand A; requester i occupies bits [32i+31:32i].
- req_b  in  32*NREQ  packed operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot grant/accept.
- rsp_valid  out  NREQ  one-hot response strobe, one cycle.
- rsp_result  out  32  product for the requester flagged by rsp_valid.
- mul_a  out  32  operand A to the shared fp_mul.
- mul_b  out  32  operand B to the shared fp_mul.
- mul_result  in  32  product from the shared fp_mul.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, WAIT, RESP. Registers: state, cnt (2 bits), grant index g, last_grant, op_a, op_b, res.
- Reset (synchronous, active-high, all registers):
  - state=IDLE, cnt=0, last_grant=NREQ-1 (so requester 0 has first priority).
  - op_a=op_b=res=0, rsp_valid=0, busy=0.
  - req_ready is forced to 0 while reset is high.
- IDLE:
  - Scan req_valid starting at (last_grant+1) mod NREQ, wrapping. The first set bit wins.
  - req_ready[win]=1 combinationally; all other ready bits are 0. No valid requester: req_ready=0, stay in IDLE.
  - A handshake is req_valid[i] & req_ready[i]. On the clock edge it latches op_a/op_b from slice i, sets g=i, cnt=LAT-1, and moves to WAIT.
- WAIT:
  - req_ready=0. mul_a=op_a and mul_b=op_b, held stable throughout.
  - cnt!=0: decrement. cnt==0: res<=mul_result, go to RESP.
  - WAIT lasts exactly LAT cycles.
- RESP:
  - rsp_valid[g]=1 for exactly one cycle; rsp_result=res. There is no backpressure; the requester must consume it.
  - Next edge: last_grant<=g, go to IDLE.
- Timing: handshake in cycle 0, rsp_valid in cycle LAT+1, next handshake possible in cycle LAT+2. Throughput is one op per LAT+2 cycles.
- Output hold rules:
  - mul_a/mul_b always drive op_a/op_b, so they keep the last operands in IDLE/RESP (no toggling).
  - rsp_result holds res between responses.
  - rsp_valid is 0 outside RESP.
- Result passthrough: no arithmetic in this block. Sign, exponent and mantissa come straight from mul_result.
- Boundary conditions:
  - NREQ=1: no arbitration; the requester is always the winner.
  - A requester deasserting valid before being granted has no effect; the request is never latched.
  - Operand changes on req_a/req_b after the handshake are ignored.
  - Reset asserted in WAIT or RESP: the operation is aborted, no rsp_valid is issued, and priority returns to requester 0.
  - All requesters valid continuously: strict rotation 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 operations.

Test Plan:
- Bench wiring: fp_mul is connected combinationally to mul_a/mul_b/mul_result.
1. NREQ=2, LAT=1, req0 a=40000000 (2.0), b=40400000 (3.0) → req_ready=01 in cycle 0; busy high in cycles 1-2; rsp_valid=01 in cycle 2 with rsp_result=40C00000 (6.0).
2. First cycle after reset, both valid: req0 = 3FC00000 (1.5) × C0000000 (-2.0), req1 = 40000000 × 40400000.
   - Cycle 0: req_ready=01. Cycle 2: rsp_valid=01, result=C0400000.
   - Cycle 3: req_ready=10. Cycle 5: rsp_valid=10, result=40C00000.
3. Both requesters valid continuously for 4 operations → grant order 0,1,0,1; handshakes exactly 3 cycles apart (LAT=1).
4. LAT=3, single request → mul_a/mul_b stable and equal to the latched operands for WAIT cycles 1-3; rsp_valid in cycle 4 only; req_ready=0 in cycles 1-4.
5. Reset pulsed in the second WAIT cycle (LAT=3) → rsp_valid never asserts. The first IDLE cycle after reset with both valid gives req_ready=01.
6. req1 valid during req0's WAIT and then withdrawn before RESP ends → no grant or response for req1. Next IDLE with only req0 valid gives req_ready=01.
